// File: rtl/bitmem_arbiter.sv
// bitmem_arbiter: round-robin arbiter and write sequencer for an 8x1 SR-latch bit memory.
// Writes run setup -> enable strobe -> hold so mem_s is stable around every enable pulse.
// Reads sample mem_q at the end of setup. Define BITMEM_ARB_WRITE_VERIFY_EN to read each
// written cell back after hold and pulse err_x with ack_x on a mismatch.
module bitmem_arbiter #(
  parameter int unsigned SETUP_CYCLES  = 1,
  parameter int unsigned STROBE_CYCLES = 2,
  parameter int unsigned HOLD_CYCLES   = 1
) (
  input  logic       HW_clk,
  input  logic       HW_rst,
  input  logic       req_a,
  input  logic       we_a,
  input  logic [2:0] addr_a,
  input  logic       wdata_a,
  output logic       gnt_a,
  output logic       ack_a,
  output logic       rdata_a,
  output logic       err_a,
  input  logic       req_b,
  input  logic       we_b,
  input  logic [2:0] addr_b,
  input  logic       wdata_b,
  output logic       gnt_b,
  output logic       ack_b,
  output logic       rdata_b,
  output logic       err_b,
  output logic       mem_s,
  output logic [7:0] mem_en,
  input  logic [7:0] mem_q
);

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StStrobe,
    StHold,
`ifdef BITMEM_ARB_WRITE_VERIFY_EN
    StVerify,
`endif
    StDone
  } state_e;

  // Counter reload values; each phase lasts (load + 1) cycles.
  localparam logic [3:0] SetupLd  = 4'(SETUP_CYCLES - 1);
  localparam logic [3:0] StrobeLd = 4'(STROBE_CYCLES - 1);
  localparam logic [3:0] HoldLd   = 4'(HOLD_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       port_b_q, port_b_d;  // transaction owner: 1 = port B
  logic       last_b_q, last_b_d;  // last served port: 1 = port B
  logic       we_q, we_d;
  logic [2:0] addr_q, addr_d;
  logic       wdata_q, wdata_d;    // forced to 0 for reads so mem_s stays low
  logic       rdata_a_q, rdata_b_q;
  logic       grant_b;
  logic       capture;
  logic       busy;
  logic       done;

  // State, counter and latched request registers
  always_ff @(posedge HW_clk or posedge HW_rst) begin
    if (HW_rst) begin
      state_q  <= StIdle;
      cnt_q    <= 4'd0;
      port_b_q <= 1'b0;
      last_b_q <= 1'b1;
      we_q     <= 1'b0;
      addr_q   <= 3'd0;
      wdata_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      port_b_q <= port_b_d;
      last_b_q <= last_b_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  // Arbitration and phase sequencing
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    port_b_d = port_b_q;
    last_b_d = last_b_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    grant_b  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_a || req_b) begin
          // On conflict the port not served last wins.
          grant_b  = req_b && (!req_a || !last_b_q);
          port_b_d = grant_b;
          last_b_d = grant_b;
          we_d     = grant_b ? we_b : we_a;
          addr_d   = grant_b ? addr_b : addr_a;
          wdata_d  = grant_b ? (we_b & wdata_b) : (we_a & wdata_a);
          cnt_d    = SetupLd;
          state_d  = StSetup;
        end
      end
      StSetup: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else if (we_q) begin
          cnt_d   = StrobeLd;
          state_d = StStrobe;
        end else begin
          state_d = StDone;
        end
      end
      StStrobe: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          cnt_d   = HoldLd;
          state_d = StHold;
        end
      end
      StHold: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
`ifdef BITMEM_ARB_WRITE_VERIFY_EN
          state_d = StVerify;
`else
          state_d = StDone;
`endif
        end
      end
`ifdef BITMEM_ARB_WRITE_VERIFY_EN
      StVerify: state_d = StDone;
`endif
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  assign capture = (state_q == StSetup) && (cnt_q == 4'd0) && !we_q;

  // Read data registers, loaded on the last setup edge of a read
  always_ff @(posedge HW_clk or posedge HW_rst) begin
    if (HW_rst) begin
      rdata_a_q <= 1'b0;
      rdata_b_q <= 1'b0;
    end else if (capture) begin
      if (port_b_q) rdata_b_q <= mem_q[addr_q];
      else          rdata_a_q <= mem_q[addr_q];
    end
  end

`ifdef BITMEM_ARB_WRITE_VERIFY_EN
  logic vbit_q;

  // Read-back sample of the written cell
  always_ff @(posedge HW_clk or posedge HW_rst) begin
    if (HW_rst)                     vbit_q <= 1'b0;
    else if (state_q == StVerify)   vbit_q <= mem_q[addr_q];
  end
`endif

  // Memory bus and port handshake outputs, decoded from state
  always_comb begin
    busy    = (state_q != StIdle);
    done    = (state_q == StDone);
    mem_s   = 1'b0;
    mem_en  = 8'd0;
    gnt_a   = busy && !port_b_q;
    gnt_b   = busy && port_b_q;
    ack_a   = done && !port_b_q;
    ack_b   = done && port_b_q;
    rdata_a = rdata_a_q;
    rdata_b = rdata_b_q;
    err_a   = 1'b0;
    err_b   = 1'b0;
    if (busy && !done) mem_s = wdata_q;
    if (state_q == StStrobe) mem_en = 8'(1) << addr_q;
`ifdef BITMEM_ARB_WRITE_VERIFY_EN
    err_a = ack_a && we_q && (vbit_q != wdata_q);
    err_b = ack_b && we_q && (vbit_q != wdata_q);
`endif
  end

endmodule

// File: tb/tb_bitmem_arbiter.sv
// tb_bitmem_arbiter: directed stimulus, a transaction-level model checked every cycle,
// and literal expectations for latencies, enables and grant order.
module tb_bitmem_arbiter;

  localparam int unsigned SetupN  = 1;
  localparam int unsigned StrobeN = 2;
  localparam int unsigned HoldN   = 1;
`ifdef BITMEM_ARB_WRITE_VERIFY_EN
  localparam int unsigned VerifyN = 1;
  localparam int WrLit = 6;
  localparam int T4Lit = 8;
`else
  localparam int unsigned VerifyN = 0;
  localparam int WrLit = 5;
  localparam int T4Lit = 7;
`endif
  localparam int RdLit = 2;

  logic       HW_clk, HW_rst;
  logic       req_a, we_a, wdata_a, req_b, we_b, wdata_b;
  logic [2:0] addr_a, addr_b;
  logic       gnt_a, ack_a, rdata_a, err_a, gnt_b, ack_b, rdata_b, err_b;
  logic       mem_s;
  logic [7:0] mem_en, mem_q;
  logic [7:0] cells, force0;

  int nvec = 0;
  int nerr = 0;

  assign mem_q = cells & ~force0;

  bitmem_arbiter #(
    .SETUP_CYCLES (SetupN),
    .STROBE_CYCLES(StrobeN),
    .HOLD_CYCLES  (HoldN)
  ) dut (
    .HW_clk (HW_clk),
    .HW_rst (HW_rst),
    .req_a  (req_a),
    .we_a   (we_a),
    .addr_a (addr_a),
    .wdata_a(wdata_a),
    .gnt_a  (gnt_a),
    .ack_a  (ack_a),
    .rdata_a(rdata_a),
    .err_a  (err_a),
    .req_b  (req_b),
    .we_b   (we_b),
    .addr_b (addr_b),
    .wdata_b(wdata_b),
    .gnt_b  (gnt_b),
    .ack_b  (ack_b),
    .rdata_b(rdata_b),
    .err_b  (err_b),
    .mem_s  (mem_s),
    .mem_en (mem_en),
    .mem_q  (mem_q)
  );

  initial HW_clk = 1'b0;
  always #5 HW_clk = ~HW_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  bit       m_busy = 0;
  int       m_port = 0;
  bit       m_we = 0;
  logic [2:0] m_addr = 0;
  bit       m_wdata = 0;
  int       m_t = 0;
  int       m_len = 0;
  bit       m_last_b = 1;
  bit       m_rd [2] = '{0, 0};
  bit       m_vbit = 0;
  bit       m_rst_req = 0;

  task automatic model_reset();
    m_busy = 0; m_last_b = 1; m_rd[0] = 0; m_rd[1] = 0; m_t = 0;
  endtask

  function automatic bit memv(input logic [2:0] a);
    return cells[a] & ~force0[a];
  endfunction

  // Compare on the falling edge, then let the cells latch, then predict the next rising edge.
  initial begin
    logic [7:0] e_en;
    bit e_s, e_ga, e_gb, e_aa, e_ab, e_ea, e_eb;
    forever begin
      @(negedge HW_clk);
      if (m_rst_req || HW_rst) begin
        model_reset();
        m_rst_req = 0;
      end
      if (!HW_rst) begin
        e_en = 8'd0; e_s = 0; e_ga = 0; e_gb = 0; e_aa = 0; e_ab = 0; e_ea = 0; e_eb = 0;
        if (m_busy) begin
          e_ga = (m_port == 0);
          e_gb = (m_port == 1);
          if (m_t == m_len) begin
            e_aa = e_ga;
            e_ab = e_gb;
            if (VerifyN != 0 && m_we && (m_vbit != m_wdata)) begin
              e_ea = e_ga;
              e_eb = e_gb;
            end
          end else begin
            e_s = m_we & m_wdata;
          end
          if (m_we && m_t > SetupN && m_t <= SetupN + StrobeN) e_en = 8'(1) << m_addr;
        end
        chk("gnt_a", gnt_a, e_ga);
        chk("gnt_b", gnt_b, e_gb);
        chk("ack_a", ack_a, e_aa);
        chk("ack_b", ack_b, e_ab);
        chk("err_a", err_a, e_ea);
        chk("err_b", err_b, e_eb);
        chk("rdata_a", rdata_a, m_rd[0]);
        chk("rdata_b", rdata_b, m_rd[1]);
        chk("mem_s", mem_s, e_s);
        chk("mem_en", mem_en, e_en);
      end
      for (int i = 0; i < 8; i++) if (mem_en[i]) cells[i] = mem_s;
      if (!HW_rst) begin
        if (m_busy) begin
          if (m_t == m_len) begin
            m_busy = 0;
          end else begin
            m_t++;
            if (m_t == m_len) begin
              if (!m_we) m_rd[m_port] = memv(m_addr);
              else       m_vbit = memv(m_addr);
            end
          end
        end else if (req_a || req_b) begin
          if (req_a && req_b) m_port = m_last_b ? 0 : 1;
          else                m_port = req_b ? 1 : 0;
          m_last_b = (m_port == 1);
          m_we     = (m_port == 1) ? we_b : we_a;
          m_addr   = (m_port == 1) ? addr_b : addr_a;
          m_wdata  = m_we & ((m_port == 1) ? wdata_b : wdata_a);
          m_len    = m_we ? int'(SetupN + StrobeN + HoldN + VerifyN + 1) : int'(SetupN + 1);
          m_t      = 1;
          m_busy   = 1;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge HW_clk);
    #1;
  endtask

  // One transaction with req held until ack; returns cycles from SETUP (=1) to ack.
  task automatic txn(input bit port, input bit we, input logic [2:0] addr, input bit wd,
                     output int lat, output int nen, output logic [7:0] en_or,
                     output logic err);
    lat = -1; nen = 0; en_or = 8'd0; err = 1'b0;
    if (!port) begin req_a = 1; we_a = we; addr_a = addr; wdata_a = wd; end
    else       begin req_b = 1; we_b = we; addr_b = addr; wdata_b = wd; end
    tick();
    for (int n = 1; n <= 20; n++) begin
      if (n == 1) begin
        // Inputs changing after grant must not matter.
        if (!port) begin addr_a = ~addr; wdata_a = ~wd; end
        else       begin addr_b = ~addr; wdata_b = ~wd; end
      end
      if (mem_en != 8'd0) nen++;
      en_or |= mem_en;
      if (port ? ack_b : ack_a) begin
        lat = n;
        err = port ? err_b : err_a;
        break;
      end
      tick();
    end
    if (!port) req_a = 0; else req_b = 0;
    tick();
  endtask

  initial begin
    int lat, nen, nack, gb_first;
    logic [7:0] en_or;
    logic err;
    logic [3:0] order;

    HW_rst = 1; req_a = 0; we_a = 0; addr_a = 0; wdata_a = 0;
    req_b = 0; we_b = 0; addr_b = 0; wdata_b = 0; cells = 8'd0; force0 = 8'd0;
    #12;
    chk("reset_outputs", {gnt_a, ack_a, rdata_a, err_a, gnt_b, ack_b, rdata_b, err_b, mem_s},
        32'd0);
    chk("reset_mem_en", mem_en, 32'd0);
    @(posedge HW_clk); #1; HW_rst = 0;
    tick(); tick();

    // 1: A writes 1 to cell 5
    txn(0, 1, 3'd5, 1, lat, nen, en_or, err);
    chk("t1_latency", lat, WrLit);
    chk("t1_strobe_cycles", nen, 2);
    chk("t1_strobe_onehot", en_or, 8'h20);
    chk("t1_cell5", mem_q[5], 1);
    chk("t1_rdata_untouched", rdata_a, 0);

    // 2: A reads cell 5
    txn(0, 0, 3'd5, 0, lat, nen, en_or, err);
    chk("t2_latency", lat, RdLit);
    chk("t2_no_enable", en_or, 8'h00);
    chk("t2_rdata_a", rdata_a, 1);

    // B reads cell 5 so B is last served and A wins the next conflict
    txn(1, 0, 3'd5, 0, lat, nen, en_or, err);
    chk("t2b_latency", lat, RdLit);
    chk("t2b_rdata_b", rdata_b, 1);

    // 3: simultaneous held requests alternate A, B, A, B
    req_a = 1; we_a = 1; addr_a = 3'd0; wdata_a = 1;
    req_b = 1; we_b = 1; addr_b = 3'd7; wdata_b = 1;
    nack = 0; order = 4'd0;
    for (int n = 0; n < 60 && nack < 4; n++) begin
      tick();
      if (ack_a) begin order = {order[2:0], 1'b0}; nack++; end
      else if (ack_b) begin order = {order[2:0], 1'b1}; nack++; end
    end
    req_a = 0; req_b = 0;
    tick();
    chk("t3_acks", nack, 4);
    chk("t3_order", order, 4'b0101);
    chk("t3_cells", mem_q, 8'ha1);

    // 4: B requests during A's strobe; granted after the IDLE cycle following ack_a
    req_a = 1; we_a = 1; addr_a = 3'd6; wdata_a = 1;
    we_b = 0; addr_b = 3'd6; wdata_b = 0;
    gb_first = -1;
    tick();
    for (int n = 1; n <= 30; n++) begin
      if (n == 2) req_b = 1;
      if (ack_a) req_a = 0;
      if (gnt_b && gb_first < 0) gb_first = n;
      if (ack_b) begin req_b = 0; break; end
      tick();
    end
    req_a = 0; req_b = 0;
    tick();
    chk("t4_gnt_b_cycle", gb_first, T4Lit);
    chk("t4_rdata_b", rdata_b, 1);

    // 5: reset during strobe of a write to cell 3
    req_a = 1; we_a = 1; addr_a = 3'd3; wdata_a = 1;
    tick(); tick();
    chk("t5_strobe_en", mem_en, 8'h08);
    #1 HW_rst = 1;
    #1;
    chk("t5_rst_mem_en", mem_en, 8'h00);
    chk("t5_rst_gnt_a", gnt_a, 0);
    chk("t5_rst_mem_s", mem_s, 0);
    m_rst_req = 1;
    req_a = 0;
    #1 HW_rst = 0;
    nack = 0;
    for (int n = 0; n < 6; n++) begin
      tick();
      if (ack_a) nack++;
    end
    chk("t5_no_ack", nack, 0);
    chk("t5_other_cells", mem_q & 8'hf7, 8'he1);
    txn(0, 1, 3'd3, 1, lat, nen, en_or, err);
    chk("t5_rewrite_latency", lat, WrLit);
    chk("t5_cells_after", mem_q, 8'he9);

`ifdef BITMEM_ARB_WRITE_VERIFY_EN
    // 6: forced-low cell flags a verify error; unforced repeat does not
    force0 = 8'h04;
    txn(0, 1, 3'd2, 1, lat, nen, en_or, err);
    chk("t6_latency", lat, 6);
    chk("t6_err", err, 1);
    force0 = 8'h00;
    txn(0, 1, 3'd2, 1, lat, nen, en_or, err);
    chk("t6_repeat_err", err, 0);
`else
    // Without verify, a write to a stuck cell still completes with no error
    force0 = 8'h04;
    txn(0, 1, 3'd2, 1, lat, nen, en_or, err);
    chk("t6_latency", lat, 5);
    chk("t6_err", err, 0);
    force0 = 8'h00;
`endif

    tick(); tick();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
